bus_sync_sched: RTL and testbench

Source-domain scheduler that shares one multi-bit bus-synchronizer channel between two requesters. It arbitrates, latches the winning word, and drives the synchronizer's data bus and enable level for a runtime-programmable hold window, then enforces a low gap. This keeps the data stable across the destination's synchronizer stages and gives the destination edge detector a clean rising edge per word. It sits in the transmitting clock domain, directly in front of the bus synchronizer's unsynchronized inputs.

---
 rtl/bus_sync_pkg.sv | 15 +
 rtl/bus_sync_sched_rr_arb2.sv | 49 ++++
 rtl/bus_sync_sched.sv | 107 ++++++++++
 tb/tb_bus_sync_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_sync_pkg.sv
// Shared types for the bus synchronizer scheduler.
// State encoding and one-hot grant constants.
package bus_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

endpackage

// File: rtl/bus_sync_sched_rr_arb2.sv
// Two-input arbiter, round-robin on last winner.
// SYNC_SCHED_FIXED_PRIO_EN: fixed priority, req0 wins ties.
module rr_arb2
  import bus_sync_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] gnt
);

`ifdef SYNC_SCHED_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{CLK, RST, accept};

  // req0 always first
  always_comb begin
    gnt = GNT_NONE;
    if (valid[0])
      gnt = GNT_0;
    else if (valid[1])
      gnt = GNT_1;
  end
`else
  // set when req1 won last; reset favours req0
  logic last1;

  // remember the winner of each accepted word
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      last1 <= 1'b1;
    else if (accept)
      last1 <= gnt[1];
  end

  // on a tie the previous loser goes first
  always_comb begin
    gnt = GNT_NONE;
    case (valid)
      2'b01:   gnt = GNT_0;
      2'b10:   gnt = GNT_1;
      2'b11:   gnt = last1 ? GNT_0 : GNT_1;
      default: gnt = GNT_NONE;
    endcase
  end
`endif

endmodule

// File: rtl/bus_sync_sched.sv
// Shares one bus-synchronizer channel between two requesters.
// Optional SYNC_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration.
module bus_sync_sched
  import bus_sync_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] req0_data,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [BUS_WIDTH-1:0] req1_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [CNT_WIDTH-1:0] hold_len,
  input  logic [CNT_WIDTH-1:0] gap_len,
  output logic [BUS_WIDTH-1:0] sync_data,
  output logic                 sync_enable,
  output logic [1:0]           grant,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] gap_q, gap_d;
  logic [CNT_WIDTH-1:0] hold_m1;
  logic [1:0]           gnt;
  logic                 accept;

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .gnt    (gnt)
  );

  // hold of 0 behaves as 1
  assign hold_m1 = (hold_len == '0) ? '0 : hold_len - ONE;

  assign req0_ready = accept & gnt[0];
  assign req1_ready = accept & gnt[1];
  assign busy       = (state_q != IDLE);

  // next state, countdown and accept strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (RST && gnt != GNT_NONE) begin
          accept  = 1'b1;
          state_d = HOLD;
          cnt_d   = hold_m1;
          gap_d   = gap_len;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (gap_q != '0) begin
            state_d = GAP;
            cnt_d   = gap_q - ONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      GAP: begin
        if (cnt_q == '0)
          state_d = IDLE;
        else
          cnt_d = cnt_q - ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counters and registered synchronizer outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      sync_data   <= '0;
      sync_enable <= 1'b0;
      grant       <= GNT_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      sync_enable <= (state_d == HOLD);
      if (accept) begin
        sync_data <= gnt[0] ? req0_data : req1_data;
        grant     <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_bus_sync_sched.sv
// Directed bench for bus_sync_sched.
// Define SYNC_SCHED_FIXED_PRIO_EN to match a fixed-priority build.
module tb_bus_sync_sched;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [4:0] hold_len, gap_len;
  logic [7:0] sync_data;
  logic       sync_enable;
  logic [1:0] grant;
  logic       busy;

  int errs  = 0;
  int total = 0;

  always #5 CLK = ~CLK;

  bus_sync_sched dut (
    .CLK         (CLK),
    .RST         (RST),
    .req0_data   (req0_data),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req1_data   (req1_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .hold_len    (hold_len),
    .gap_len     (gap_len),
    .sync_data   (sync_data),
    .sync_enable (sync_enable),
    .grant       (grant),
    .busy        (busy)
  );

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset;
    RST = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  logic [7:0] exp_d;
  bit         en1 [6]  = '{1, 1, 1, 0, 0, 0};
  bit         bz1 [6]  = '{1, 1, 1, 1, 1, 0};
  bit         en4 [11] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    req0_data = 8'h00;
    req1_data = 8'h00;
    hold_len  = 5'd3;
    gap_len   = 5'd2;
    RST       = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge CLK);
    req0_valid = 1'b1;
    #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_en", sync_enable, 0);
    check("rst_busy", busy, 0);

    // single word, H=3 G=2
    do_reset;
    hold_len  = 5'd3;
    gap_len   = 5'd2;
    req0_data = 8'hA5;
    req0_valid = 1'b1;
    #1;
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    check("t1_data0", sync_data, 8'h00);
    step;
    req0_valid = 1'b0;
    check("t1_data", sync_data, 8'hA5);
    check("t1_grant", grant, 2'b01);
    check("t1_ready_hold", req0_ready, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_en%0d", i), sync_enable, en1[i]);
      check($sformatf("t1_busy%0d", i), busy, bz1[i]);
      step;
    end

    // both valid, H=1 G=0
    do_reset;
    hold_len  = 5'd1;
    gap_len   = 5'd0;
    req0_data = 8'h11;
    req1_data = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("t2_ready0", req0_ready, 1);
    for (int i = 1; i <= 8; i++) begin
      step;
`ifdef SYNC_SCHED_FIXED_PRIO_EN
      exp_d = 8'h11;
`else
      exp_d = (((i - 1) / 2) % 2 == 0) ? 8'h11 : 8'h22;
`endif
      check($sformatf("t2_both%0d", i),
            req0_ready & req1_ready, 0);
      check($sformatf("t2_en%0d", i), sync_enable, i % 2);
      check($sformatf("t2_data%0d", i), sync_data, exp_d);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // hold_len 0 acts as 1
    do_reset;
    hold_len  = 5'd0;
    gap_len   = 5'd0;
    req1_data = 8'h5A;
    req1_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step;
      check($sformatf("t3_en%0d", i), sync_enable, i % 2);
      check($sformatf("t3_grant%0d", i), grant, 2'b10);
    end
    req1_valid = 1'b0;

    // hold_len change mid-HOLD
    do_reset;
    hold_len  = 5'd2;
    gap_len   = 5'd0;
    req0_data = 8'h77;
    req0_valid = 1'b1;
    step;
    hold_len = 5'd7;
    for (int i = 0; i < 11; i++) begin
      check($sformatf("t4_en%0d", i + 1), sync_enable, en4[i]);
      if (i == 3)
        req0_valid = 1'b0;
      step;
    end

    // reset during HOLD
    do_reset;
    hold_len  = 5'd5;
    gap_len   = 5'd0;
    req0_data = 8'h3C;
    req0_valid = 1'b1;
    step;
    req0_valid = 1'b0;
    step;
    check("t5_data", sync_data, 8'h3C);
    check("t5_en", sync_enable, 1);
    RST = 1'b0;
    req1_data  = 8'h99;
    req1_valid = 1'b1;
    #1;
    check("t5_rst_en", sync_enable, 0);
    check("t5_rst_data", sync_data, 8'h00);
    check("t5_rst_grant", grant, 2'b00);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready1", req1_ready, 0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("t5_ready1", req1_ready, 1);
    step;
    req1_valid = 1'b0;
    check("t5_data1", sync_data, 8'h99);
    check("t5_grant1", grant, 2'b10);
    check("t5_en1", sync_enable, 1);

    // req1 data churns while waiting
    do_reset;
    hold_len  = 5'd3;
    gap_len   = 5'd2;
    req1_data = 8'hD0;
    req1_valid = 1'b1;
    step;
    for (int i = 1; i <= 5; i++) begin
      req1_data = 8'hD0 + 8'(i);
      if (i == 5)
        req1_valid = 1'b0;
      #1;
      check($sformatf("t6_data%0d", i), sync_data, 8'hD0);
      check($sformatf("t6_en%0d", i), sync_enable, i <= 3);
      step;
    end

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
